// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared types and state encodings for the bit-serial arithmetic
//            blocks (serial adder and serial subtractor).
// Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

  // Raw state encodings, kept as constants so sibling serial datapaths can
  // decode the same values without depending on the enum type.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } sfa_state_t;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit combinational full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_full_adder
// Purpose  : Bit-serial WIDTH-bit adder computing a + b + c_in one bit per
//            clock, LSB first, through one full-adder cell and a registered
//            carry. Start/busy/done handshake; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module serial_full_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Counter holds 0..WIDTH so it never wraps inside one operation.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sfa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             c_out_q, c_out_d;

  logic             w_fa_s;
  logic             w_fa_cy;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_word;

  full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (w_fa_s),
    .c_out (w_fa_cy)
  );

  assign w_load = (state_q != RUN) && start;
  assign w_step = (state_q == RUN);

  // Result assembly. Only WIDTH-1 bits need storing: the final sum bit comes
  // straight from the cell on the edge that enters DONE.
  if (WIDTH > 1) begin : g_res_multi
    logic [WIDTH-2:0] res_q, res_d;

    // Next-state for the partial-result shift register (new bit at the MSB).
    always_comb begin
      res_d = res_q;
      if (w_load) begin
        res_d = '0;
      end else if (w_step) begin
        res_d = (WIDTH-1)'({w_fa_s, res_q} >> 1);
      end
    end

    // Partial-result register.
    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= '0;
      end else begin
        res_q <= res_d;
      end
    end

    assign w_word = {w_fa_s, res_q};
  end else begin : g_res_single
    assign w_word = w_fa_s;
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here; operands are already captured.
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = w_fa_cy;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          sum_d   = w_word;
          c_out_d = w_fa_cy;
        end
      end
      DONE: begin
        // Back-to-back restart with no idle gap when start is already high.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, carry, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule : serial_full_adder
`default_nettype wire

// File: tb/tb_serial_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_full_adder
// Purpose  : Directed, table-driven self-checking bench for serial_full_adder
//            at WIDTH=8 and WIDTH=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_full_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
  } vec1_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       c8 = 1'b0;
  logic       busy8, done8, c_out8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c1 = 1'b0;
  logic       busy1, done1, c_out1;
  logic [0:0] sum1;

  int errors = 0;
  int checks = 0;

  vec8_t v8 [8];
  vec1_t v1 [8];

  always #5 clk = ~clk;

  serial_full_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .c_in  (c8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .c_out (c_out8)
  );

  serial_full_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (c1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (c_out1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One WIDTH=8 operation from start to the cycle after done.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic [7:0] es, input logic ec,
                         input logic [7:0] ps, input logic pc);
    logic ok;
    @(negedge clk);
    a8 = ta; b8 = tb_; c8 = tc; start8 = 1'b1;
    @(negedge clk);                        // cycle 1 after start edge
    start8 = 1'b0;
    check("hold_prev_result", {23'd0, c_out8, sum8}, {23'd0, pc, ps});
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (!(busy8 === 1'b1 && done8 === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    check("busy_window", {31'd0, ok}, 32'd1);
    check("done_cycle", {30'd0, busy8, done8}, 32'd1);
    check("result", {23'd0, c_out8, sum8}, {23'd0, ec, es});
    @(negedge clk);
    check("done_one_cycle", {30'd0, busy8, done8}, 32'd0);
  endtask

  initial begin
    logic [7:0] prev_s;
    logic       prev_c;
    int         ndone;

    v8[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    v8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v8[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    v8[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    v8[5] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    v8[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    v8[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_w8", {21'd0, busy8, done8, c_out8, sum8}, 32'd0);
    check("reset_w1", {28'd0, busy1, done1, c_out1, sum1}, 32'd0);
    rst = 1'b0;

    // Table of independent WIDTH=8 operations; each also checks that the
    // previous result is still held during the next RUN.
    prev_s = 8'h00;
    prev_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_op8(v8[i].a, v8[i].b, v8[i].cin, v8[i].sum, v8[i].cout, prev_s, prev_c);
      prev_s = v8[i].sum;
      prev_c = v8[i].cout;
    end

    // start pulsed during RUN cycle 3 must be ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;         // cycle 1
    @(negedge clk);                        // cycle 2
    @(negedge clk);                        // cycle 3
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;         // cycle 4
    repeat (5) @(negedge clk);             // cycle 9
    check("ign_done", {30'd0, busy8, done8}, 32'd1);
    check("ign_result", {23'd0, c_out8, sum8}, {23'd0, 1'b0, 8'h30});
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    check("ign_no_second_op", ndone, 0);

    // Reset in RUN cycle 5 aborts the operation
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;         // cycle 1
    repeat (4) @(negedge clk);             // cycle 5
    check("abort_busy_before", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {21'd0, busy8, done8, c_out8, sum8}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Back-to-back: start held high, second op restarts on the DONE cycle
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b1; start8 = 1'b1;
    @(negedge clk);                        // cycle 1
    repeat (8) @(negedge clk);             // cycle 9
    check("b2b_done1", {30'd0, busy8, done8}, 32'd1);
    check("b2b_result1", {23'd0, c_out8, sum8}, {23'd0, 1'b0, 8'h04});
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    @(negedge clk);                        // cycle 1 of second op
    check("b2b_no_gap", {30'd0, busy8, done8}, 32'd2);
    start8 = 1'b0;
    repeat (8) @(negedge clk);             // cycle 9 of second op
    check("b2b_done2", {30'd0, busy8, done8}, 32'd1);
    check("b2b_result2", {23'd0, c_out8, sum8}, {23'd0, 1'b1, 8'h00});
    @(negedge clk);
    check("b2b_idle", {30'd0, busy8, done8}, 32'd0);

    // WIDTH=1 truth table: done two cycles after the start edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = v1[i].a; b1 = v1[i].b; c1 = v1[i].cin; start1 = 1'b1;
      @(negedge clk);                      // cycle 1
      start1 = 1'b0;
      check("w1_busy", {30'd0, busy1, done1}, 32'd2);
      @(negedge clk);                      // cycle 2
      check("w1_done", {30'd0, busy1, done1}, 32'd1);
      check("w1_result", {30'd0, c_out1, sum1}, {30'd0, v1[i].cout, v1[i].sum});
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_full_adder
`default_nettype wire
